axi_mux: RTL
============

# axi_mux

Write-path AXI N:1 multiplexer, the mirror of `axi_demux`. It merges `INPUT_NUM` upstream masters onto one downstream slave port.
- AW requests are granted round-robin.
- W bursts are forwarded in AW-grant order.
- B responses are routed back to the owning input by BID, using the same `ID_ROUTING` table as `axi_demux`.
- It sits between NoC master-side ports and a shared target.

## Interface
Parameters:
- `INPUT_NUM`, default 3: number of upstream master ports.
- `ID_ROUTING`, default '{0,1,2,3}: `INPUT_NUM+1` ascending bounds. Input i owns IDs in [`ID_ROUTING[i]`, `ID_ROUTING[i+1]`).
- `W_ORDER_DEPTH`, default 4: depth of the W-ordering FIFO, a power of 2.

Ports (structs `axi_mosi_t` / `axi_miso_t`; ID 4 b, WDATA 32 b, WSTRB 4 b):
- `ACLK` in 1: clock. One clock domain; everything is sampled on the rising edge.
- `ARESET` in 1: reset, synchronous, active-high.
- `s_axi_i[INPUT_NUM]` in `axi_mosi_t`: upstream masters. The block uses AWVALID, data.aw.*, WVALID, data.w.*, BREADY.
- `s_axi_o[INPUT_NUM]` out `axi_miso_t`: to upstream masters. The block drives AWREADY, WREADY, BVALID, data.b.BID; all other fields are 0.
- `m_axi_o` out `axi_mosi_t`: to the downstream slave. The block drives AWVALID, data.aw.*, WVALID, data.w.*, BREADY; all other fields are 0.
- `m_axi_i` in `axi_miso_t`: from the downstream slave. The block uses AWREADY, WREADY, BVALID, data.b.BID.

## Operation
AW arbiter, states IDLE and LOCK:
- **IDLE**
  - If the order FIFO is not full, select the first input with AWVALID=1, scanning round-robin from `rr_ptr`.
  - Forward its AW fields and AWVALID to `m_axi_o` combinationally. `s_axi_o[sel].AWREADY` = `m_axi_i.AWREADY`.
  - Handshake this cycle: push `sel` into the order FIFO, set `rr_ptr <= sel+1` (mod `INPUT_NUM`), stay in IDLE.
  - No handshake: latch `sel` into `lock_idx` and go to LOCK. AWVALID must not be re-arbitrated once presented.
- **LOCK**
  - Forward only `lock_idx`.
  - On handshake: push `lock_idx`, set `rr_ptr <= lock_idx+1`, return to IDLE.
- While the order FIFO is full, `m_axi_o.AWVALID`=0 and all AWREADY=0. This applies in IDLE only; LOCK is entered only when the FIFO is not full, so it cannot be entered full.
- Non-selected inputs always see AWREADY=0.

W path:
- While the FIFO is non-empty, head = h.
  - `m_axi_o.WVALID` = `s_axi_i[h].WVALID`; W fields are copied from input h.
  - `s_axi_o[h].WREADY` = `m_axi_i.WREADY`.
  - Every other input sees WREADY=0.
- On a W handshake with WLAST=1, pop the FIFO.
- While the FIFO is empty, `m_axi_o.WVALID`=0 and all WREADY=0. W data arriving before its AW is accepted is stalled, never dropped.
- Push and pop in the same cycle are allowed; occupancy is unchanged.

B path, combinational:
- Decode `m_axi_i.data.b.BID` against `ID_ROUTING` to get index k.
  - `s_axi_o[k].BVALID` = `m_axi_i.BVALID`, and BID is passed unchanged.
  - `m_axi_o.BREADY` = `s_axi_i[k].BREADY`.
- If BID matches no range, the response is dropped: BREADY=1 and no upstream BVALID is raised.

Reset (`ARESET`=1 at a rising edge):
- State goes to IDLE, `rr_ptr`=0, `lock_idx`=0, FIFO is emptied.
- Outputs during and after reset: all AWREADY, WREADY, BVALID = 0; `m_axi_o` AWVALID, WVALID, BREADY = 0.
- Reset mid-burst discards in-flight ordering. No recovery is attempted.

## Timing
- AW, W and B all pass through with 0-cycle combinational latency; there are no pipeline registers.
- The first W beat of a burst can be forwarded at the earliest in the cycle after its AW handshake, because the FIFO push is registered.
- Back-to-back AW grants are possible, one per cycle, up to `W_ORDER_DEPTH` outstanding bursts.
- The round-robin pointer advances only on an AW handshake, never on a mere request.
- There is no combinational path from a `m_axi_i.*READY` input to any `m_axi_o.*VALID` output.

## Test plan
1. **Round-robin fairness.** Inputs 0, 1 and 2 hold AWVALID with IDs 0, 1, 2; downstream AWREADY=1. Required: grant order 0, 1, 2, 0; exactly one handshake per cycle; FIFO order 0, 1, 2.
2. **Stall lock.** Input 1 asserts AWVALID while downstream AWREADY=0 for 3 cycles, and input 0 raises AWVALID in cycle 2. Required: `m_axi_o` keeps input 1's AWID/ADDR stable until AWREADY, then input 0 is granted next.
3. **W ordering.** AW from input 2 (LEN=1), then AW from input 0 (LEN=1). Input 0 presents W first. Required: input 0 sees WREADY=0 until input 2's WLAST beat handshakes; then input 0's two beats pass, and `m_axi_o` shows data 1, 2 with WLAST on beat 2.
4. **FIFO full.** With `W_ORDER_DEPTH`=4, issue 4 AWs and withhold W. Required: the 5th AWVALID sees AWREADY=0 and `m_axi_o.AWVALID`=0 until one WLAST pops the FIFO; it is accepted in that cycle or later.
5. **B routing.** Downstream returns BID=2, then BID=0, then BID=9. Required: BVALID appears on input 2, then input 0, each with BID unchanged; BID=9 is consumed with BREADY=1 and no upstream BVALID.
6. **Reset mid-operation.** Assert `ARESET` with 2 bursts outstanding and input 1 in LOCK. Required: the next cycle shows every ready/valid output at 0, the FIFO empty and state IDLE; the next AW from input 0 is granted first.

Source files
------------

// File: rtl/axi_mux.sv
// axi_mux: write-path AXI N:1 mux, round-robin AW, AW-ordered W, BID-routed B.
package axi_mux_pkg;
  typedef struct packed {
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
  } aw_t;
  typedef struct packed {
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
  } w_t;
  typedef struct packed {
    logic [3:0] BID;
  } b_t;
  typedef struct packed {
    aw_t aw;
    w_t  w;
  } mosi_data_t;
  typedef struct packed {
    b_t b;
  } miso_data_t;
  typedef struct packed {
    logic       AWVALID;
    logic       WVALID;
    logic       BREADY;
    mosi_data_t data;
  } axi_mosi_t;
  typedef struct packed {
    logic       AWREADY;
    logic       WREADY;
    logic       BVALID;
    miso_data_t data;
  } axi_miso_t;
endpackage

module axi_mux import axi_mux_pkg::*; #(
  parameter int INPUT_NUM = 3,
  parameter int ID_ROUTING [INPUT_NUM+1] = '{0, 1, 2, 3},
  parameter int W_ORDER_DEPTH = 4
) (
  input  logic      ACLK,
  input  logic      ARESET,
  input  axi_mosi_t s_axi_i [INPUT_NUM],
  output axi_miso_t s_axi_o [INPUT_NUM],
  output axi_mosi_t m_axi_o,
  input  axi_miso_t m_axi_i
);
  localparam int IW = INPUT_NUM > 1 ? $clog2(INPUT_NUM) : 1;
  localparam int PW = W_ORDER_DEPTH > 1 ? $clog2(W_ORDER_DEPTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] rr_ptr, lock_idx, sel, gnt, head, bk;
  logic          found, full, empty, aw_ok, w_ok, aw_hs, pop, hit;
  logic [IW-1:0] order [W_ORDER_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;

  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int j = 0; j < INPUT_NUM; j++)
      if (!found && s_axi_i[(int'(rr_ptr) + j) % INPUT_NUM].AWVALID) begin
        found = 1'b1;
        sel = IW'((int'(rr_ptr) + j) % INPUT_NUM);
      end
  end

  always_comb begin
    hit = 1'b0;
    bk = '0;
    for (int i = 0; i < INPUT_NUM; i++)
      if (!hit && int'(m_axi_i.data.b.BID) >= ID_ROUTING[i] && int'(m_axi_i.data.b.BID) < ID_ROUTING[i+1]) begin
        hit = 1'b1;
        bk = IW'(i);
      end
  end

  // LOCK can only be entered with room in the FIFO, so it never checks full
  assign full  = cnt == (PW+1)'(W_ORDER_DEPTH);
  assign empty = cnt == '0;
  assign head  = order[rd_ptr];
  assign gnt   = state == LOCK ? lock_idx : sel;
  assign aw_ok = !ARESET && (state == LOCK || (!full && found));
  assign w_ok  = !ARESET && !empty;
  assign aw_hs = m_axi_o.AWVALID && m_axi_i.AWREADY;
  assign pop   = m_axi_o.WVALID && m_axi_i.WREADY && s_axi_i[head].data.w.WLAST;

  always_comb begin
    m_axi_o = '0;
    m_axi_o.AWVALID = aw_ok && s_axi_i[gnt].AWVALID;
    m_axi_o.data.aw = s_axi_i[gnt].data.aw;
    m_axi_o.WVALID = w_ok && s_axi_i[head].WVALID;
    m_axi_o.data.w = s_axi_i[head].data.w;
    m_axi_o.BREADY = !ARESET && (hit ? s_axi_i[bk].BREADY : 1'b1);
  end

  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      s_axi_o[i] = '0;
      s_axi_o[i].AWREADY = aw_ok && gnt == IW'(i) && m_axi_i.AWREADY;
      s_axi_o[i].WREADY = w_ok && head == IW'(i) && m_axi_i.WREADY;
      s_axi_o[i].BVALID = !ARESET && hit && bk == IW'(i) && m_axi_i.BVALID;
      s_axi_o[i].data.b.BID = hit && bk == IW'(i) ? m_axi_i.data.b.BID : '0;
    end
  end

  always_ff @(posedge ACLK)
    if (aw_hs) order[wr_ptr] <= gnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock_idx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (aw_hs) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= gnt == IW'(INPUT_NUM-1) ? '0 : gnt + 1'b1;
        state <= IDLE;
      end else if (state == IDLE && m_axi_o.AWVALID) begin
        state <= LOCK;
        lock_idx <= sel;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(aw_hs) - (PW+1)'(pop);
    end
  end
endmodule
